serial_add_sub: RTL and testbench

- Parametrised, multi-cycle, digit-serial adder/subtractor built around the team's full-adder cell.
- Processes DIGIT bits per clock with a registered carry. Completes a WIDTH-bit add or subtract in WIDTH/DIGIT cycles.
- Uses a start/busy/done handshake so the datapath can trade area for latency on wide operands.
- Successor to the single-bit combinational adders: adds width, subtract mode, overflow flag and sequencing.

---
 rtl/serial_add_sub.sv | 109 ++++++++++
 tb/tb_serial_add_sub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a full-adder ripple,
// registered carry between digits, start/busy/done handshake around a three-state FSM.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one digit per edge, STEPS edges total
// DONE  | result valid for one cycle (done=1), start accepted back-to-back
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
    logic [IW-1:0]    base;
    logic             carry;
    logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
    logic             dig_cout, msb_carry;
    logic             last_step, accept;

    assign last_step = (base == IW'(WIDTH - DIGIT));
    assign accept    = start && (state != RUN);

    // Subtract is a + ~b + ~cin, so the inverted operand and carry are latched up front.
    always_comb begin
        logic c;
        dig_a     = op_a[base +: DIGIT];
        dig_b     = op_b[base +: DIGIT];
        dig_sum   = '0;
        msb_carry = 1'b0;
        c         = carry;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) msb_carry = c;
            dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c;
            c          = (dig_a[i] & dig_b[i]) | (c & (dig_a[i] ^ dig_b[i]));
        end
        dig_cout = c;
        res_nxt  = res;
        res_nxt[base +: DIGIT] = dig_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            base  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            base  <= '0;
        end else if (state == RUN) begin
            res   <= res_nxt;
            carry <= dig_cout;
            base  <= base + IW'(DIGIT);
            if (last_step) begin
                sum  <= res_nxt;
                cout <= dig_cout;
                ovf  <= msb_carry ^ dig_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: cycle-level reference model for the 8/1 instance plus
// literal expectations, and a 16/4 instance checked against the arithmetic reference.
module tb_serial_add_sub;

    localparam int W = 8,  D = 1, STEPS = 8;
    localparam int W2 = 16, D2 = 4, STEPS2 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start, sub, cin, busy, done, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic          start2, sub2, cin2, busy2, done2, cout2, ovf2;
    logic [W2-1:0] a2, b2, sum2;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

    serial_add_sub #(.WIDTH(W2), .DIGIT(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} computed with plain integer arithmetic.
    function automatic logic [65:0] ref_op(input int w, input logic s,
                                           input longint unsigned x, input longint unsigned y,
                                           input logic c);
        longint unsigned m, r, half_u;
        longint          sx, sy, sv, half;
        logic            co, ov;
        m      = (64'd1 << w) - 64'd1;
        half_u = 64'd1 << (w - 1);
        half   = longint'(half_u);
        sx     = (x >= half_u) ? longint'(x) - 2 * half : longint'(x);
        sy     = (y >= half_u) ? longint'(y) - 2 * half : longint'(y);
        if (!s) begin
            r  = x + y + 64'(c);
            co = ((r >> w) != 0);
            sv = sx + sy + longint'(c);
        end else begin
            co = (x >= y + 64'(c));
            r  = x - y - 64'(c);
            sv = sx - sy - longint'(c);
        end
        ov = (sv >= half) || (sv < -half);
        return {ov, co, r & m};
    endfunction

    // Protocol model: STEPS edges after acceptance the result is published with done.
    int           m_left;
    logic         m_busy, m_done, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    logic [65:0]  m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_sum  <= m_pend[W-1:0];
                m_cout <= m_pend[64];
                m_ovf  <= m_pend[65];
            end
        end else if (start) begin
            m_pend <= ref_op(W, sub, 64'(a), 64'(b), cin);
            m_left <= STEPS;
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("result", {22'd0, cout, ovf, sum}, {22'd0, m_cout, m_ovf, m_sum});
    end

    task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start = 1'b1; sub = s; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int nb);
        bit ok;
        ok = 1'b0;
        nb = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (done) ok = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] es, input logic ec, input logic ev);
        check({name, "_sum"},  32'(sum),  32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_ovf"},  32'(ovf),  32'(ev));
    endtask

    task automatic op2(input logic s, input logic [W2-1:0] x, input logic [W2-1:0] y, input logic c,
                       output int nb);
        bit ok;
        ok = 1'b0;
        nb = 0;
        start2 = 1'b1; sub2 = s; a2 = x; b2 = y; cin2 = c;
        @(negedge clk);
        start2 = 1'b0;
        a2 = W2'($urandom);
        b2 = W2'($urandom);
        for (int i = 0; i < 40 && !ok; i++) begin
            if (done2) ok = 1'b1;
            else begin
                if (busy2) nb++;
                @(negedge clk);
            end
        end
        check("done2_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        int          nb, seen;
        logic [65:0] r2;
        logic [W2-1:0] x2, y2;
        logic        s2, c2;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        expect_res("rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        launch(1'b0, 8'h01, 8'h01, 1'b0);
        wait_done(nb);
        check("busy_len_1p1", 32'(nb), 32'(STEPS));
        expect_res("add_1p1", 8'h02, 1'b0, 1'b0);
        @(negedge clk);

        launch(1'b0, 8'hFF, 8'h01, 1'b0);
        wait_done(nb);
        expect_res("add_ff", 8'h00, 1'b1, 1'b0);
        launch(1'b0, 8'h7F, 8'h01, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(nb);
        check("busy_len_b2b", 32'(nb), 32'(STEPS));
        expect_res("add_7f", 8'h80, 1'b0, 1'b1);
        @(negedge clk);

        launch(1'b1, 8'h05, 8'h07, 1'b0);
        wait_done(nb);
        expect_res("sub_5_7", 8'hFE, 1'b0, 1'b0);
        launch(1'b1, 8'h80, 8'h01, 1'b0);
        wait_done(nb);
        expect_res("sub_80_1", 8'h7F, 1'b1, 1'b1);
        launch(1'b1, 8'h10, 8'h03, 1'b1);
        wait_done(nb);
        expect_res("sub_10_3b", 8'h0C, 1'b1, 1'b0);
        @(negedge clk);

        launch(1'b0, 8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'hAA; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrun_hold", 32'(sum), 32'h0C);
        wait_done(nb);
        expect_res("midrun", 8'h46, 1'b0, 1'b0);
        @(negedge clk);

        launch(1'b0, 8'h55, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        expect_res("arst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        launch(1'b0, 8'h55, 8'h22, 1'b0);
        wait_done(nb);
        expect_res("post_rst", 8'h77, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            launch(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            wait_done(nb);
            check("busy_len_rand", 32'(nb), 32'(STEPS));
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        op2(1'b0, 16'h8000, 16'h8000, 1'b0, nb);
        check("w16_busy_len", 32'(nb), 32'(STEPS2));
        check("w16_sum",  32'(sum2),  32'h0000);
        check("w16_cout", 32'(cout2), 32'd1);
        check("w16_ovf",  32'(ovf2),  32'd1);
        for (int i = 0; i < 30; i++) begin
            x2 = W2'($urandom); y2 = W2'($urandom); s2 = 1'($urandom); c2 = 1'($urandom);
            r2 = ref_op(W2, s2, 64'(x2), 64'(y2), c2);
            op2(s2, x2, y2, c2, nb);
            check("w16_rand_len", 32'(nb), 32'(STEPS2));
            check("w16_rand_res", {13'd0, cout2, ovf2, sum2}, {13'd0, r2[64], r2[65], r2[W2-1:0]});
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
